// File: rtl/gray_updown_nbits.sv
// Parametrised N-bit up/down Gray counter with load, wrap/saturate mode, tc and wrap flags.
// Optional sticky Gray-step checker enabled by defining GRAY_STEP_CHECK_EN.
module gray_updown_nbits #(
    parameter int N    = 4,
    parameter int INIT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    input  logic         up_dn,
    input  logic         sat_mode,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] gray_out,
    output logic [N-1:0] bin_out,
    output logic         tc,
`ifdef GRAY_STEP_CHECK_EN
    output logic         wrapped,
    output logic         step_err
`else
    output logic         wrapped
`endif
);

    localparam logic [N-1:0] INIT_B = INIT[N-1:0];
    localparam logic [N-1:0] MAX_B  = '1;

    logic [N-1:0] b;
    logic [N-1:0] next_b;
    logic         next_wrap;

    assign bin_out = b;
    assign tc      = (up_dn & (b == MAX_B)) | (~up_dn & (b == '0));

    // Next binary value; gray is always derived from it so both outputs stay in step.
    always_comb begin
        next_b    = b;
        next_wrap = 1'b0;
        if (load) begin
            next_b = load_val;
        end else if (clk_en) begin
            if (tc) begin
                if (!sat_mode) begin
                    next_b    = up_dn ? '0 : MAX_B;
                    next_wrap = 1'b1;
                end
            end else begin
                next_b = up_dn ? (b + N'(1)) : (b - N'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b        <= INIT_B;
            gray_out <= INIT_B ^ (INIT_B >> 1);
            wrapped  <= 1'b0;
        end else begin
            b        <= next_b;
            gray_out <= next_b ^ (next_b >> 1);
            wrapped  <= next_wrap;
        end
    end

`ifdef GRAY_STEP_CHECK_EN
    logic [N-1:0] prev_gray;
    logic         prev_skip;
    logic [N-1:0] gray_diff;
    logic         multi_bit;

    assign gray_diff = gray_out ^ prev_gray;
    assign multi_bit = |(gray_diff & (gray_diff - N'(1)));

    // prev_skip marks that the edge which produced gray_out was a load or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_gray <= INIT_B ^ (INIT_B >> 1);
            prev_skip <= 1'b1;
            step_err  <= 1'b0;
        end else begin
            prev_gray <= gray_out;
            prev_skip <= load;
            if (!prev_skip && multi_bit) begin
                step_err <= 1'b1;
            end
        end
    end
`endif

endmodule
